mem_port_arbiter: RTL and testbench

Arbitrates one single-ported, variable-latency memory between the instruction-fetch stage and the load/store stage of the xgriscv pipeline. It latches the granted request, drives the memory handshake and routes the response back. It also produces the fetch and memory stall signals that gate the PC register and the pipeline flops. Data accesses win by default, and a bounded starvation guard protects fetch.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between instruction fetch and load/store,
// with data accesses preferred and a bounded starvation guard for fetch.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ready,
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [3:0]      ls_amp,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic [XLEN-1:0] ls_rdata,
    output logic            ls_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [3:0]      mem_be,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            stall_f,
    output logic            stall_m,
    output logic            bus_err
);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_LS} state_t;

    localparam logic [3:0]      STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0]      WAIT_LAST  = 8'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] WORD_MASK  = {{(XLEN-2){1'b1}}, 2'b00};

    state_t          state;
    state_t          state_next;
    logic [3:0]      starve_cnt;
    logic [3:0]      starve_next;
    logic [7:0]      wait_cnt;
    logic [XLEN-1:0] lat_addr;
    logic [XLEN-1:0] lat_wdata;
    logic            lat_we;
    logic [3:0]      lat_be;
    logic            busy;
    logic            at_limit;
    logic            done;
    logic            timed_out;
    logic            grant_if;
    logic            grant_ls;

    assign busy      = (state != IDLE);
    assign at_limit  = (wait_cnt == WAIT_LAST);
    assign done      = busy && (mem_ack || at_limit);
    assign timed_out = busy && at_limit && !mem_ack;

    // Grant decision in IDLE; a BUSY state always returns through IDLE, so a
    // requester still holding req in its ack cycle cannot be re-granted.
    always_comb begin
        state_next  = state;
        grant_if    = 1'b0;
        grant_ls    = 1'b0;
        starve_next = starve_cnt;
        case (state)
            IDLE: begin
                if (ls_req && !(if_req && starve_cnt == STARVE_MAX)) begin
                    grant_ls   = 1'b1;
                    state_next = BUSY_LS;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_LS: begin
                if (done) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        if (grant_if) begin
            starve_next = 4'd0;
        end else if (grant_ls) begin
            if (!if_req) begin
                starve_next = 4'd0;
            end else if (starve_cnt != STARVE_MAX) begin
                starve_next = starve_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
            wait_cnt   <= 8'd0;
            bus_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_we     <= 1'b0;
            lat_be     <= 4'd0;
        end else begin
            state      <= state_next;
            starve_cnt <= starve_next;
            wait_cnt   <= (busy && !done) ? wait_cnt + 8'd1 : 8'd0;
            if (timed_out) begin
                bus_err <= 1'b1;
            end
            if (grant_if) begin
                lat_addr  <= if_addr & WORD_MASK;
                lat_wdata <= '0;
                lat_we    <= 1'b0;
                lat_be    <= 4'b1111;
            end else if (grant_ls) begin
                lat_addr  <= ls_addr & WORD_MASK;
                lat_wdata <= ls_wdata;
                lat_we    <= ls_we;
                lat_be    <= ls_amp;
            end
        end
    end

    // A completion coinciding with reset is discarded, so ready is masked by reset.
    always_comb begin
        mem_req   = busy;
        mem_we    = busy && lat_we;
        mem_be    = busy ? lat_be : 4'd0;
        mem_addr  = busy ? lat_addr : '0;
        mem_wdata = busy ? lat_wdata : '0;
        if_ready  = (state == BUSY_IF) && done && !reset;
        ls_ready  = (state == BUSY_LS) && done && !reset;
        if_rdata  = (if_ready && mem_ack) ? mem_rdata : '0;
        ls_rdata  = (ls_ready && mem_ack) ? mem_rdata : '0;
        stall_f   = if_req && !if_ready;
        stall_m   = ls_req && !ls_ready;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter: a bench-side memory responder
// returns address-derived data, and per-requester queues hold the expected words.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_amp;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [31:0] ls_rdata;
    logic        ls_ready;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_f;
    logic        stall_m;
    logic        bus_err;

    int checks   = 0;
    int failures = 0;
    int ack_lat  = 1;
    int busy_seen = 0;
    int cur_lat   = 0;

    logic [31:0] if_q[$];
    logic [31:0] ls_q[$];
    logic [31:0] exp_q[$];

    mem_port_arbiter #(.XLEN(32), .STARVE_LIMIT(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .ls_req(ls_req), .ls_we(ls_we), .ls_amp(ls_amp), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ready(ls_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_m(stall_m), .bus_err(bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hC3A5_0F69;
    endfunction

    // Memory responder: acks in the ack_lat-th request cycle (0 = random 1..8,
    // negative = never); stray acks and junk data appear while idle.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                busy_seen++;
                if (busy_seen == 1) begin
                    cur_lat = (ack_lat == 0) ? int'($urandom_range(1, 8)) : ack_lat;
                end
                if (busy_seen == cur_lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem_model(mem_addr);
                end else begin
                    mem_ack   = 1'b0;
                    mem_rdata = $urandom;
                end
            end else begin
                busy_seen = 0;
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample_point();
        @(negedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit is_ls, input logic req, input logic [31:0] addr,
                                 input logic we, input logic [3:0] amp, input logic [31:0] wdata);
        if (is_ls) begin
            ls_req   = req;
            ls_addr  = addr;
            ls_we    = we;
            ls_amp   = amp;
            ls_wdata = wdata;
        end else begin
            if_req  = req;
            if_addr = addr;
        end
    endtask

    // One isolated transfer; the requester scrambles its inputs after the grant.
    task automatic run_one(input bit is_ls, input logic [31:0] addr, input logic we,
                           input logic [3:0] amp, input logic [31:0] wdata,
                           input int lat, input bit exp_to);
        logic [31:0] aligned;
        int          busy_n;
        bit          got;
        aligned = {addr[31:2], 2'b00};
        next_cycle();
        ack_lat = lat;
        applyStimulus(is_ls, 1'b1, addr, we, amp, wdata);
        exp_q.push_back(exp_to ? 32'd0 : mem_model(aligned));
        sample_point();
        checkOutput("req_latency", 32'(mem_req), 32'd0);
        checkOutput("stall_wait", 32'(is_ls ? stall_m : stall_f), 32'd1);
        busy_n = 0;
        got    = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            next_cycle();
            applyStimulus(is_ls, 1'b1, ~addr, ~we, ~amp, ~wdata);
            sample_point();
            busy_n++;
            checkOutput("mem_req_held", 32'(mem_req), 32'd1);
            checkOutput("mem_addr", mem_addr, aligned);
            checkOutput("mem_we", 32'(mem_we), 32'(is_ls ? we : 1'b0));
            checkOutput("mem_be", 32'(mem_be), 32'(is_ls ? amp : 4'hF));
            if (is_ls) checkOutput("mem_wdata", mem_wdata, wdata);
            checkOutput("other_ready", 32'(is_ls ? if_ready : ls_ready), 32'd0);
            if (is_ls ? ls_ready : if_ready) begin
                got = 1'b1;
                checkOutput("rdata", is_ls ? ls_rdata : if_rdata, exp_q.pop_front());
                checkOutput("busy_cycles", 32'(busy_n), 32'(exp_to ? 8 : lat));
                checkOutput("stall_ack", 32'(is_ls ? stall_m : stall_f), 32'd0);
            end
        end
        checkOutput("ready_seen", 32'(got), 32'd1);
        next_cycle();
        applyStimulus(is_ls, 1'b0, addr, we, amp, wdata);
        sample_point();
        checkOutput("idle_after", 32'(mem_req), 32'd0);
        checkOutput("ready_low_after", 32'(is_ls ? ls_ready : if_ready), 32'd0);
    endtask

    // Concurrent traffic from both requesters with scoreboard checking of returned data.
    task automatic traffic(input int n_if, input int n_ls, input bit starve_mode, input int budget);
        int          if_left;
        int          ls_left;
        int          grants;
        int          cyc;
        bit          if_fin;
        bit          ls_fin;
        bit          prev_done;
        bit          prev_req;
        logic [31:0] if_next;
        if_left = n_if;   ls_left = n_ls;  grants = 0;  cyc = 0;
        if_fin = 1'b0;    ls_fin = 1'b0;   prev_done = 1'b0;  prev_req = 1'b0;
        if_next = 32'h8000_1000;
        while ((if_left > 0 || ls_left > 0 || if_req || ls_req) && cyc < budget) begin
            next_cycle();
            if (if_fin) begin if_req = 1'b0; if_fin = 1'b0; end
            if (ls_fin) begin ls_req = 1'b0; ls_fin = 1'b0; end
            if (!if_req && if_left > 0 && (starve_mode || $urandom_range(0, 2) == 0)) begin
                if_req  = 1'b1;
                if_addr = if_next;
                if_next = if_next + 32'd4;
                if_q.push_back(mem_model(if_addr));
                if_left--;
            end
            if (!ls_req && ls_left > 0 && (starve_mode || $urandom_range(0, 2) == 0)) begin
                ls_req   = 1'b1;
                ls_addr  = 32'h9000_0000 | (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(0, 3));
                ls_we    = 1'($urandom_range(0, 1));
                ls_amp   = 4'($urandom_range(1, 15));
                ls_wdata = $urandom;
                ls_q.push_back(mem_model(ls_addr));
                ls_left--;
            end
            sample_point();
            if (prev_done) checkOutput("idle_gap", 32'(mem_req), 32'd0);
            if (starve_mode && mem_req && !prev_req) begin
                checkOutput("grant_order", 32'(mem_addr[31:28] == 4'h8), 32'(grants % 5 == 4));
                grants++;
            end
            if (if_ready) begin
                checkOutput("if_ready_expected", 32'(if_req && if_q.size() > 0), 32'd1);
                if (if_q.size() > 0) checkOutput("if_rdata", if_rdata, if_q.pop_front());
                if_fin = 1'b1;
            end
            if (ls_ready) begin
                checkOutput("ls_ready_expected", 32'(ls_req && ls_q.size() > 0), 32'd1);
                if (ls_q.size() > 0) checkOutput("ls_rdata", ls_rdata, ls_q.pop_front());
                ls_fin = 1'b1;
            end
            prev_done = if_ready || ls_ready;
            prev_req  = mem_req;
            cyc++;
        end
        checkOutput("traffic_budget", 32'(cyc < budget), 32'd1);
        checkOutput("if_all_served", 32'(if_q.size()), 32'd0);
        checkOutput("ls_all_served", 32'(ls_q.size()), 32'd0);
        if (starve_mode) checkOutput("grant_count", 32'(grants), 32'(n_if + n_ls));
        if_req = 1'b0;
        ls_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1;  if_req = 1'b0;  if_addr = 32'd0;
        ls_req = 1'b0; ls_we = 1'b0;   ls_amp = 4'd0;  ls_addr = 32'd0;  ls_wdata = 32'd0;
        next_cycle();
        next_cycle();
        if_req = 1'b1;
        sample_point();
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_if_ready", 32'(if_ready), 32'd0);
        checkOutput("reset_bus_err", 32'(bus_err), 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_stall_f", 32'(stall_f), 32'd1);
        checkOutput("reset_stall_m", 32'(stall_m), 32'd0);
        next_cycle();
        reset  = 1'b0;
        if_req = 1'b0;
        sample_point();
        checkOutput("idle_no_req", 32'(mem_req), 32'd0);

        $display("[TB] single fetch");
        run_one(1'b0, 32'h8000_0000, 1'b0, 4'hF, 32'd0, 1, 1'b0);

        $display("[TB] starvation guard");
        ack_lat = 1;
        traffic(3, 12, 1'b1, 200);

        $display("[TB] byte store");
        run_one(1'b1, 32'h8000_0103, 1'b1, 4'b1000, 32'hAB00_0000, 3, 1'b0);

        $display("[TB] ack in last cycle");
        run_one(1'b0, 32'h8000_0200, 1'b0, 4'hF, 32'd0, 8, 1'b0);
        checkOutput("late_ack_no_err", 32'(bus_err), 32'd0);

        $display("[TB] timeout");
        run_one(1'b1, 32'h9000_0040, 1'b0, 4'hF, 32'd0, -1, 1'b1);
        checkOutput("timeout_err", 32'(bus_err), 32'd1);
        run_one(1'b0, 32'h8000_0300, 1'b0, 4'hF, 32'd0, 2, 1'b0);
        checkOutput("err_sticky", 32'(bus_err), 32'd1);

        $display("[TB] reset during BUSY_LS");
        next_cycle();
        ack_lat = 2;
        applyStimulus(1'b1, 1'b1, 32'h9000_0100, 1'b0, 4'hF, 32'd0);
        sample_point();
        checkOutput("rst_pre_idle", 32'(mem_req), 32'd0);
        next_cycle();
        sample_point();
        checkOutput("rst_busy", 32'(mem_req), 32'd1);
        next_cycle();
        reset = 1'b1;
        sample_point();
        checkOutput("rst_no_ready", 32'(ls_ready), 32'd0);
        checkOutput("rst_no_rdata", ls_rdata, 32'd0);
        checkOutput("rst_stall_m", 32'(stall_m), 32'd1);
        next_cycle();
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'h9000_0100, 1'b0, 4'hF, 32'd0);
        sample_point();
        checkOutput("rst_req_dropped", 32'(mem_req), 32'd0);
        checkOutput("rst_ready_low", 32'(ls_ready), 32'd0);
        checkOutput("rst_err_clear", 32'(bus_err), 32'd0);

        $display("[TB] random traffic");
        ack_lat = 0;
        traffic(15, 15, 1'b0, 3000);
        checkOutput("random_no_err", 32'(bus_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
